// File: rtl/vbs_pkg.sv
// Shared constants and FSM state type for the variable-block-size SAD search.
package vbs_pkg;
  localparam int NUM_PART = 41;
  localparam int P4X4     = 0;
  localparam int P8X4     = 16;
  localparam int P4X8     = 24;
  localparam int P8X8     = 32;
  localparam int P16X8    = 36;
  localparam int P8X16    = 38;
  localparam int P16X16   = 40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;
endpackage

// File: rtl/vbs_sad_tree.sv
// Two-stage registered adder tree: 16 4x4 SADs -> all 41 partition SADs, MV and valid ride along.
module vbs_sad_tree
  import vbs_pkg::*;
#(
  parameter int SAD4_WIDTH = 12,
  parameter int SAD_WIDTH  = 16,
  parameter int MV_WIDTH   = 7
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [16*SAD4_WIDTH-1:0]           sad4x4,
  input  logic [MV_WIDTH-1:0]                in_mv_x,
  input  logic [MV_WIDTH-1:0]                in_mv_y,
  output logic                               out_valid,
  output logic                               pipe_busy,
  output logic [NUM_PART-1:0][SAD_WIDTH-1:0] sad,
  output logic [MV_WIDTH-1:0]                out_mv_x,
  output logic [MV_WIDTH-1:0]                out_mv_y
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [MV_WIDTH-1:0] x;
    logic [MV_WIDTH-1:0] y;
  } mv_t;

  logic [STAGES:0]                   vld_pipe;
  mv_t                               mv_in;
  mv_t [STAGES:1]                    mv_q;
  logic [15:0][SAD_WIDTH-1:0]        a;
  logic [P8X8-1:0][SAD_WIDTH-1:0]    s1_d, s1_q;
  logic [3:0][SAD_WIDTH-1:0]         b8;
  logic [NUM_PART-1:0][SAD_WIDTH-1:0] s2_d, s2_q;

  assign vld_pipe[0] = in_valid;
  assign mv_in       = '{x: in_mv_x, y: in_mv_y};

  genvar k, r, c;
  generate
    for (k = 0; k < 16; k++) begin : g_ext
      assign a[k] = SAD_WIDTH'(sad4x4[k*SAD4_WIDTH +: SAD4_WIDTH]);
    end

    // Stage 1: 4x4 pass-through, horizontal (8x4) and vertical (4x8) pairs
    for (r = 0; r < 4; r++) begin : g_r4
      for (c = 0; c < 4; c++) begin : g_c4
        assign s1_d[P4X4 + r*4 + c] = a[r*4 + c];
      end
      for (c = 0; c < 2; c++) begin : g_c84
        assign s1_d[P8X4 + r*2 + c] = a[r*4 + 2*c] + a[r*4 + 2*c + 1];
      end
    end
    for (r = 0; r < 2; r++) begin : g_r48
      for (c = 0; c < 4; c++) begin : g_c48
        assign s1_d[P4X8 + r*4 + c] = a[2*r*4 + c] + a[(2*r+1)*4 + c];
      end
    end

    // Stage 2: 8x8 from stacked 8x4 pairs, larger blocks from 8x8 quads
    for (r = 0; r < 2; r++) begin : g_r88
      for (c = 0; c < 2; c++) begin : g_c88
        assign b8[r*2 + c] = s1_q[P8X4 + (2*r)*2 + c] + s1_q[P8X4 + (2*r+1)*2 + c];
      end
    end
    for (k = 0; k < 2; k++) begin : g_big
      assign s2_d[P16X8 + k] = b8[2*k] + b8[2*k + 1];
      assign s2_d[P8X16 + k] = b8[k] + b8[2 + k];
    end
  endgenerate

  assign s2_d[P8X8-1:0]       = s1_q;
  assign s2_d[P8X8 +: 4]      = b8;
  assign s2_d[P16X16]         = b8[0] + b8[1] + b8[2] + b8[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      mv_q               <= '0;
      s1_q               <= '0;
      s2_q               <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (vld_pipe[0]) begin
        s1_q    <= s1_d;
        mv_q[1] <= mv_in;
      end
      if (vld_pipe[1]) begin
        s2_q    <= s2_d;
        mv_q[2] <= mv_q[1];
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign pipe_busy = |vld_pipe[STAGES:1];
  assign sad       = s2_q;
  assign out_mv_x  = mv_q[STAGES].x;
  assign out_mv_y  = mv_q[STAGES].y;
endmodule

// File: rtl/vbs_sad_min_search.sv
// VBS SAD aggregation with per-partition running minimum over a search run, valid/ready result port.
module vbs_sad_min_search
  import vbs_pkg::*;
#(
  parameter int SAD4_WIDTH = 12,
  parameter int SAD_WIDTH  = 16,
  parameter int MV_WIDTH   = 7,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [16*SAD4_WIDTH-1:0]      in_sad4x4,
  input  logic [MV_WIDTH-1:0]           in_mv_x,
  input  logic [MV_WIDTH-1:0]           in_mv_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_PART*SAD_WIDTH-1:0] out_min_sad,
  output logic [NUM_PART*MV_WIDTH-1:0]  out_mv_x,
  output logic [NUM_PART*MV_WIDTH-1:0]  out_mv_y,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          cand_count
);
  generate
    if (SAD_WIDTH < SAD4_WIDTH + 4) begin : g_width_chk
      $error("SAD_WIDTH must be at least SAD4_WIDTH+4");
    end
  endgenerate

  state_t state_q, state_d;
  logic   in_fire, clear;

  logic                               tree_vld, tree_busy;
  logic [NUM_PART-1:0][SAD_WIDTH-1:0] tree_sad;
  logic [MV_WIDTH-1:0]                tree_mv_x, tree_mv_y;

  logic [NUM_PART-1:0][SAD_WIDTH-1:0] min_sad;
  logic [NUM_PART-1:0][MV_WIDTH-1:0]  min_mv_x, min_mv_y;

  assign in_ready  = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign in_fire   = in_valid && in_ready;
  assign clear     = (state_q == ST_IDLE) && start;

  vbs_sad_tree #(
    .SAD4_WIDTH (SAD4_WIDTH),
    .SAD_WIDTH  (SAD_WIDTH),
    .MV_WIDTH   (MV_WIDTH)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_fire),
    .sad4x4    (in_sad4x4),
    .in_mv_x   (in_mv_x),
    .in_mv_y   (in_mv_y),
    .out_valid (tree_vld),
    .pipe_busy (tree_busy),
    .sad       (tree_sad),
    .out_mv_x  (tree_mv_x),
    .out_mv_y  (tree_mv_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (in_fire && in_last) state_d = ST_FLUSH;
      ST_FLUSH: if (!tree_busy) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cand_count <= '0;
    else if (clear)   cand_count <= '0;
    else if (in_fire) cand_count <= cand_count + 1'b1;
  end

  // Strict less-than: on a tie the earlier candidate keeps the slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_sad  <= '1;
      min_mv_x <= '0;
      min_mv_y <= '0;
    end else if (clear) begin
      min_sad  <= '1;
      min_mv_x <= '0;
      min_mv_y <= '0;
    end else if (tree_vld) begin
      for (int p = 0; p < NUM_PART; p++) begin
        if (tree_sad[p] < min_sad[p]) begin
          min_sad[p]  <= tree_sad[p];
          min_mv_x[p] <= tree_mv_x;
          min_mv_y[p] <= tree_mv_y;
        end
      end
    end
  end

  assign out_min_sad = min_sad;
  assign out_mv_x    = min_mv_x;
  assign out_mv_y    = min_mv_y;
endmodule

// File: tb/tb_vbs_sad_min_search.sv
// Directed bench for vbs_sad_min_search: rectangle-sum reference model feeding a result scoreboard.
module tb_vbs_sad_min_search;
  localparam int S4 = 12, SW = 16, MW = 7, CW = 12, NP = 41;
  localparam int WIDE = NP*SW;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_last, out_ready;
  logic in_ready, out_valid, busy;
  logic [16*S4-1:0] in_sad4x4;
  logic [MW-1:0]    in_mv_x, in_mv_y;
  logic [NP*SW-1:0] out_min_sad;
  logic [NP*MW-1:0] out_mv_x, out_mv_y;
  logic [CW-1:0]    cand_count;

  always #5 clk = ~clk;

  vbs_sad_min_search #(.SAD4_WIDTH(S4), .SAD_WIDTH(SW), .MV_WIDTH(MW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_sad4x4(in_sad4x4), .in_mv_x(in_mv_x), .in_mv_y(in_mv_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_min_sad(out_min_sad),
    .out_mv_x(out_mv_x), .out_mv_y(out_mv_y), .busy(busy), .cand_count(cand_count)
  );

  typedef struct packed {
    logic [NP*SW-1:0] sad;
    logic [NP*MW-1:0] mx;
    logic [NP*MW-1:0] my;
    logic [CW-1:0]    cnt;
  } exp_t;

  exp_t          sb[$];
  logic [SW-1:0] m_sad[NP];
  logic [MW-1:0] m_mx[NP], m_my[NP];
  int            m_cnt;
  int            n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [WIDE-1:0] got, input logic [WIDE-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Partition as a rectangle of 4x4 blocks (x0,y0,w,h), summed directly
  function automatic logic [SW-1:0] part_sad(input logic [16*S4-1:0] s, input int p);
    int x0, y0, w, h, q;
    logic [SW-1:0] acc;
    if (p < 16)      begin x0 = p%4;       y0 = p/4;       w = 1; h = 1; end
    else if (p < 24) begin q = p-16; x0 = (q%2)*2; y0 = q/2;     w = 2; h = 1; end
    else if (p < 32) begin q = p-24; x0 = q%4;     y0 = (q/4)*2; w = 1; h = 2; end
    else if (p < 36) begin q = p-32; x0 = (q%2)*2; y0 = (q/2)*2; w = 2; h = 2; end
    else if (p < 38) begin q = p-36; x0 = 0;       y0 = q*2;     w = 4; h = 2; end
    else if (p < 40) begin q = p-38; x0 = q*2;     y0 = 0;       w = 2; h = 4; end
    else             begin x0 = 0; y0 = 0; w = 4; h = 4; end
    acc = '0;
    for (int y = y0; y < y0+h; y++)
      for (int x = x0; x < x0+w; x++)
        acc = acc + SW'(s[(y*4+x)*S4 +: S4]);
    return acc;
  endfunction

  function automatic logic [16*S4-1:0] fill(input int v);
    logic [16*S4-1:0] r;
    for (int k = 0; k < 16; k++) r[k*S4 +: S4] = v[S4-1:0];
    return r;
  endfunction

  function automatic logic [16*S4-1:0] rnd_sads();
    logic [16*S4-1:0] r;
    for (int k = 0; k < 16; k++) r[k*S4 +: S4] = S4'($urandom_range(0, 4095));
    return r;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < NP; p++) begin
      m_sad[p] = '1; m_mx[p] = '0; m_my[p] = '0;
    end
    m_cnt = 0;
  endtask

  task automatic model_beat(input logic [16*S4-1:0] s, input logic [MW-1:0] mx, input logic [MW-1:0] my);
    logic [SW-1:0] v;
    for (int p = 0; p < NP; p++) begin
      v = part_sad(s, p);
      if (v < m_sad[p]) begin
        m_sad[p] = v; m_mx[p] = mx; m_my[p] = my;
      end
    end
    m_cnt++;
  endtask

  task automatic push_exp();
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      e.sad[p*SW +: SW] = m_sad[p];
      e.mx[p*MW +: MW]  = m_mx[p];
      e.my[p*MW +: MW]  = m_my[p];
    end
    e.cnt = CW'(m_cnt);
    sb.push_back(e);
  endtask

  // Begins a run; a beat offered alongside start must not be taken
  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1; in_sad4x4 = fill(0); in_mv_x = MW'(9); in_mv_y = MW'(9);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    model_clear();
    @(negedge clk);
    chk("start_count", cand_count, 0);
    chk("start_ready", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [16*S4-1:0] s, input logic [MW-1:0] mx, input logic [MW-1:0] my,
                           input bit last, input int gap);
    bit ok = 1'b0;
    in_valid = 1'b1; in_sad4x4 = s; in_mv_x = mx; in_mv_y = my; in_last = last;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk("beat_accept", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_beat(s, mx, my);
    if (last) push_exp();
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_result(input bit hold);
    bit   ok = 1'b0;
    exp_t e;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
    end
    chk("out_valid", ok, 1);
    chk("sb_pending", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("min_sad", out_min_sad, e.sad);
      chk("mv_x", out_mv_x, e.mx);
      chk("mv_y", out_mv_y, e.my);
      chk("cand_count", cand_count, e.cnt);
      if (hold) begin
        for (int i = 0; i < 10; i++) begin
          if (i == 3) start = 1'b1;
          if (i == 4) start = 1'b0;
          chk("hold_valid", out_valid, 1);
          chk("hold_sad", out_min_sad, e.sad);
          @(negedge clk);
        end
        chk("hold_busy", busy, 1);
        chk("hold_mv_x", out_mv_x, e.mx);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("valid_drop", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready", in_ready, 0);
      chk("idle_keep", out_min_sad, e.sad);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16*S4-1:0] sb_b;
    logic [16*S4-1:0] beats[4];
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_sad4x4 = '0; in_mv_x = '0; in_mv_y = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", cand_count, 0);
    chk("rst_sad", out_min_sad, {WIDE{1'b1}});
    chk("rst_mv", out_mv_x, 0);
    @(posedge clk); #1 rst = 1'b0;

    // beats offered in IDLE are ignored
    in_valid = 1'b1; in_sad4x4 = fill(0);
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("idle_ignore", cand_count, 0);

    // 1: single-beat run
    do_start();
    send_beat(fill(1), MW'(3), MW'(-2), 1'b1, 0);
    wait_result(1'b0);
    chk("t1_p0", out_min_sad[0*SW +: SW], 1);
    chk("t1_p16", out_min_sad[16*SW +: SW], 2);
    chk("t1_p24", out_min_sad[24*SW +: SW], 2);
    chk("t1_p32", out_min_sad[32*SW +: SW], 4);
    chk("t1_p36", out_min_sad[36*SW +: SW], 8);
    chk("t1_p39", out_min_sad[39*SW +: SW], 8);
    chk("t1_p40", out_min_sad[40*SW +: SW], 16);
    chk("t1_mvx40", out_mv_x[40*MW +: MW], 7'h03);
    chk("t1_mvy40", out_mv_y[40*MW +: MW], 7'h7e);

    // 2: second beat wins only where it is strictly smaller
    do_start();
    sb_b = fill(20);
    sb_b[0 +: S4] = '0;
    send_beat(fill(10), MW'(1), MW'(1), 1'b0, 0);
    send_beat(sb_b, MW'(-1), MW'(0), 1'b1, 0);
    wait_result(1'b0);
    chk("t2_p0", out_min_sad[0*SW +: SW], 0);
    chk("t2_p0_mvx", out_mv_x[0*MW +: MW], 7'h7f);
    chk("t2_p1", out_min_sad[1*SW +: SW], 10);
    chk("t2_p1_mvx", out_mv_x[1*MW +: MW], 7'h01);
    chk("t2_p16", out_min_sad[16*SW +: SW], 20);
    chk("t2_p16_mvx", out_mv_x[16*MW +: MW], 7'h01);
    chk("t2_p40", out_min_sad[40*SW +: SW], 160);
    chk("t2_p40_mvy", out_mv_y[40*MW +: MW], 7'h01);

    // 3: ties keep the earliest candidate
    do_start();
    sb_b = rnd_sads();
    send_beat(sb_b, MW'(2), MW'(2), 1'b0, 0);
    send_beat(sb_b, MW'(5), MW'(5), 1'b1, 0);
    wait_result(1'b0);
    chk("t3_mvx40", out_mv_x[40*MW +: MW], 7'h02);
    chk("t3_mvy0", out_mv_y[0*MW +: MW], 7'h02);

    // 4: full-scale input, then the same beats with and without bubbles; held DONE
    do_start();
    send_beat(fill(4095), MW'(0), MW'(1), 1'b1, 0);
    wait_result(1'b0);
    chk("t4_p40", out_min_sad[40*SW +: SW], 65520);
    chk("t4_p32", out_min_sad[32*SW +: SW], 16380);
    for (int b = 0; b < 4; b++) beats[b] = rnd_sads();
    do_start();
    for (int b = 0; b < 4; b++) send_beat(beats[b], MW'(b), MW'(-b), b == 3, 3);
    wait_result(1'b0);
    do_start();
    for (int b = 0; b < 4; b++) send_beat(beats[b], MW'(b), MW'(-b), b == 3, 0);
    wait_result(1'b1);

    // 6: reset mid-run discards everything in flight
    do_start();
    for (int b = 0; b < 5; b++) send_beat(fill(b), MW'(7), MW'(7), 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_count", cand_count, 0);
    chk("mid_rst_sad", out_min_sad, {WIDE{1'b1}});
    @(posedge clk); #1 rst = 1'b0;
    do_start();
    for (int b = 0; b < 3; b++) send_beat(rnd_sads(), MW'($urandom), MW'($urandom), b == 2, b);
    wait_result(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
